mips_data_mem_responder: RTL and testbench

MIPS_DATA_MEM_RESPONDER -- requirements
Module: mips_data_mem_responder

---
 rtl/mips_data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_mips_data_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem_responder.sv
// Wait-stated single-port data memory responder for a MIPS core (IDLE/ACCESS/RESP).
// Optional byte-lane write enables are added when DMEM_BYTE_WRITE_EN is defined.
module mips_data_mem_responder #(
   parameter int unsigned WAIT_STATES = 2,
   parameter int unsigned DEPTH       = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [6:0]  addr,
   input  logic [31:0] wdata,
`ifdef DMEM_BYTE_WRITE_EN
   input  logic [3:0]  be,
`endif
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy
);

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [6:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] mem_q [DEPTH];
   logic        mem_wr;
   logic [31:0] wmask;
   logic [IW-1:0] widx;

   // Word index wraps modulo DEPTH so non-power-of-two depths stay in range.
   assign widx = IW'(addr_q[6:2] % DEPTH);

   always_comb begin
      wmask = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         wmask[i*8 +: 8] = {8{be_q[i]}};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      rdata_d = rdata_q;
      mem_wr  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
`ifdef DMEM_BYTE_WRITE_EN
               be_d    = be;
`else
               be_d    = '1;
`endif
               cnt_d   = 4'(WAIT_STATES);
               state_d = ACCESS;
               busy_d  = 1'b1;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = RESP;
               ack_d   = 1'b1;
               if (addr_q[1:0] != 2'b00) begin
                  err_d = 1'b1;
               end else if (we_q) begin
                  mem_wr = 1'b1;
               end else begin
                  rdata_d = mem_q[widx];
               end
            end
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_wr) begin
         mem_q[widx] <= (mem_q[widx] & ~wmask) | (wdata_q & wmask);
      end
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign busy  = busy_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Self-checking bench: timestamp-based transaction model plus directed literal checks.
module tb_mips_data_mem_responder;

   localparam int unsigned WS    = 2;
   localparam int unsigned DEPTH = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req = 1'b0, we = 1'b0;
   logic [6:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be_v = 4'hF;
   logic        ack, err, busy;
   logic [31:0] rdata;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [6:0]  addr0 = '0;
   logic [31:0] wdata0 = '0;
   logic        ack0, err0, busy0;
   logic [31:0] rdata0;
`ifdef DMEM_BYTE_WRITE_EN
   logic [3:0]  be0 = 4'hF;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_data_mem_responder #(.WAIT_STATES(WS), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DMEM_BYTE_WRITE_EN
      .be(be_v),
`endif
      .ack(ack), .rdata(rdata), .err(err), .busy(busy)
   );

   mips_data_mem_responder #(.WAIT_STATES(0), .DEPTH(DEPTH)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
`ifdef DMEM_BYTE_WRITE_EN
      .be(be0),
`endif
      .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request accepted at edge a completes at edge a+WS+1 and frees the port at a+WS+2.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_rdata = '0;
   logic        m_ack = 1'b0, m_err = 1'b0, m_busy = 1'b0;
   int          m_edge = 0, m_acc = 0;
   bit          m_fl = 1'b0;
   logic        m_we;
   logic [6:0]  m_addr;
   logic [31:0] m_wd, m_mask;
   logic [4:0]  m_idx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_rdata = '0; m_ack = 1'b0; m_err = 1'b0; m_busy = 1'b0;
         m_fl = 1'b0; m_edge = 0;
      end else begin
         m_edge++;
         m_ack = 1'b0;
         m_err = 1'b0;
         if (m_fl && m_edge == m_acc + WS + 1) begin
            m_ack = 1'b1;
            m_idx = 5'(m_addr[6:2] % DEPTH);
            if (m_addr[1:0] != 2'b00) m_err = 1'b1;
            else if (m_we) m_mem[m_idx] = (m_mem[m_idx] & ~m_mask) | (m_wd & m_mask);
            else m_rdata = m_mem[m_idx];
         end else if (m_fl && m_edge == m_acc + WS + 2) begin
            m_fl = 1'b0;
            m_busy = 1'b0;
         end else if (!m_fl && req) begin
            m_we = we; m_addr = addr; m_wd = wdata;
`ifdef DMEM_BYTE_WRITE_EN
            for (int i = 0; i < 4; i++) m_mask[i*8 +: 8] = {8{be_v[i]}};
`else
            m_mask = '1;
`endif
            m_acc = m_edge; m_fl = 1'b1; m_busy = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("err", 32'(err), 32'(m_err));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rdata", rdata, m_rdata);
   end

   task automatic xact(input logic w, input logic [6:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic e);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be_v = b;
      @(posedge clk);
      #1 req = 1'b0;
      lat = -1;
      e = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            lat = i;
            e = err;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   int   lat;
   logic e;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      rst_n = 1'b1;

      xact(1'b1, 7'h08, 32'hDEADBEEF, 4'hF, lat, e);
      chk("wr08_lat", 32'(lat), 32'd3);
      chk("wr08_err", 32'(e), 32'h0);
      xact(1'b0, 7'h08, 32'h0, 4'hF, lat, e);
      chk("rd08_lat", 32'(lat), 32'd3);
      chk("rd08_err", 32'(e), 32'h0);
      chk("rd08_data", rdata, 32'hDEADBEEF);

      xact(1'b1, 7'h05, 32'h12345678, 4'hF, lat, e);
      chk("mis_lat", 32'(lat), 32'd3);
      chk("mis_err", 32'(e), 32'h1);
      chk("mis_rdata_hold", rdata, 32'hDEADBEEF);
      xact(1'b0, 7'h04, 32'h0, 4'hF, lat, e);
      chk("rd04_data", rdata, 32'h0);
      chk("rd04_err", 32'(e), 32'h0);

      xact(1'b1, 7'h7C, 32'hCAFEF00D, 4'hF, lat, e);
      xact(1'b0, 7'h7C, 32'h0, 4'hF, lat, e);
      chk("rd7c_data", rdata, 32'hCAFEF00D);
      xact(1'b0, 7'h7E, 32'h0, 4'hF, lat, e);
      chk("rd7e_err", 32'(e), 32'h1);
      chk("rd7e_hold", rdata, 32'hCAFEF00D);

      // Abort a write mid-ACCESS with reset; memory must come back cleared.
      xact(1'b1, 7'h10, 32'hAAAA5555, 4'hF, lat, e);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 7'h10; wdata = 32'h11111111; be_v = 4'hF;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_busy", 32'(busy), 32'h0);
      repeat (3) begin
         @(posedge clk);
         #1 chk("rst_mid_ack", 32'(ack), 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 7'h10, 32'h0, 4'hF, lat, e);
      chk("rd10_after_rst", rdata, 32'h0);
      chk("rd10_lat", 32'(lat), 32'd3);

`ifdef DMEM_BYTE_WRITE_EN
      xact(1'b1, 7'h20, 32'hFFFFFFFF, 4'b1111, lat, e);
      xact(1'b1, 7'h20, 32'h00000000, 4'b0101, lat, e);
      xact(1'b1, 7'h20, 32'h12345678, 4'b0000, lat, e);
      chk("be0_lat", 32'(lat), 32'd3);
      xact(1'b0, 7'h20, 32'h0, 4'hF, lat, e);
      chk("be_rd", rdata, 32'hFF00FF00);
`endif

      // Zero-wait-state instance with req held high: period of three cycles.
      @(negedge clk);
      req0 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("ws0_busy", 32'(busy0), ((k % 3) != 2) ? 32'h1 : 32'h0);
         chk("ws0_ack", 32'(ack0), ((k % 3) == 1) ? 32'h1 : 32'h0);
         chk("ws0_err", 32'(err0), 32'h0);
      end
      req0 = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
